flit_injector: RTL and testbench

//  Local-port injection unit for the bufferless torus router. Accepts packet

---
 rtl/flit_injector_if.sv | 33 +++
 rtl/flit_injector.sv | 95 +++++++++
 tb/tb_flit_injector.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/flit_injector_if.sv
// Core-request and router-injection signal bundle for flit_injector.
// The master side is the core/router environment; the slave side is the injector.
interface flit_injector_if #(
  parameter int WIDTH_COORDINATE = 3,
  parameter int DATA_W           = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int TS_W             = 8,
  parameter int SEQ_W            = 4
);
  localparam int FLIT_W = 1 + 4*WIDTH_COORDINATE + TS_W + SEQ_W + DATA_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic                        req_valid;
  logic                        req_ready;
  logic [WIDTH_COORDINATE-1:0] req_dstX;
  logic [WIDTH_COORDINATE-1:0] req_dstY;
  logic [DATA_W-1:0]           req_data;
  logic                        req_err;
  logic                        inj_slot_free;
  logic                        flit_valid;
  logic [FLIT_W-1:0]           flit_out;
  logic [CNT_W-1:0]            fifo_count;

  modport master (
    output req_valid, req_dstX, req_dstY, req_data, inj_slot_free,
    input  req_ready, req_err, flit_valid, flit_out, fifo_count
  );

  modport slave (
    input  req_valid, req_dstX, req_dstY, req_data, inj_slot_free,
    output req_ready, req_err, flit_valid, flit_out, fifo_count
  );
endinterface

// File: rtl/flit_injector.sv
// Local-port injection unit: buffers core packet requests in a small FIFO and
// emits one header flit per free router injection slot, in strict FIFO order.
module flit_injector #(
  parameter int WIDTH_COORDINATE = 3,
  parameter int SIZE_NETWORK     = 8,
  parameter int CUR_X            = 0,
  parameter int CUR_Y            = 0,
  parameter int DATA_W           = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int TS_W             = 8,
  parameter int SEQ_W            = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  flit_injector_if.slave bus
);
  localparam int WC     = WIDTH_COORDINATE;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = 2*WC + TS_W + DATA_W;
  localparam int FLIT_W = 1 + 4*WC + TS_W + SEQ_W + DATA_W;

  function automatic logic coord_ok(input logic [WC-1:0] c);
    return int'(c) < SIZE_NETWORK;
  endfunction

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;
  logic [TS_W-1:0]   age;
  logic [SEQ_W-1:0]  seq;
  logic              err_p1;
  logic              vld_p1;
  logic [FLIT_W-1:0] flit_p1;

  logic              full;
  logic              accept;
  logic              push;
  logic              pop;
  logic [WC-1:0]     hd_x;
  logic [WC-1:0]     hd_y;
  logic [TS_W-1:0]   hd_ts;
  logic [DATA_W-1:0] hd_data;

  // Ready depends only on the registered count, so a full FIFO blocks a push
  // even when a pop happens on the same edge.
  assign full          = (cnt == CNT_W'(FIFO_DEPTH));
  assign bus.req_ready = rst_n & ~full;
  assign accept        = bus.req_valid & bus.req_ready;
  assign push          = accept & coord_ok(bus.req_dstX) & coord_ok(bus.req_dstY);
  assign pop           = bus.inj_slot_free & (cnt != '0);

  assign {hd_x, hd_y, hd_ts, hd_data} = mem[head];

  // Stage p0: request storage, timestamped with the age value at the enqueue edge
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {bus.req_dstX, bus.req_dstY, age, bus.req_data};
  end

  // Stage p1: header flit register, live for exactly one cycle after a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      age     <= '0;
      seq     <= '0;
      err_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      flit_p1 <= '0;
    end else begin
      age    <= age + 1'b1;
      err_p1 <= accept & ~push;
      vld_p1 <= pop;
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head <= head + 1'b1;
        seq  <= seq + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      flit_p1 <= pop ? {1'b1, WC'(CUR_X), WC'(CUR_Y), hd_x, hd_y, hd_ts, seq, hd_data}
                     : '0;
    end
  end

  assign bus.flit_valid = vld_p1;
  assign bus.flit_out   = flit_p1;
  assign bus.req_err    = err_p1;
  assign bus.fifo_count = cnt;
endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: node (1,2) on a 6x6 torus, 4-entry FIFO.
module tb_flit_injector;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flit_injector_if #(.WIDTH_COORDINATE(3), .DATA_W(32), .FIFO_DEPTH(4),
                     .TS_W(8), .SEQ_W(4)) bus ();

  flit_injector #(.WIDTH_COORDINATE(3), .SIZE_NETWORK(6), .CUR_X(1), .CUR_Y(2),
                  .DATA_W(32), .FIFO_DEPTH(4), .TS_W(8), .SEQ_W(4))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct packed {
    logic [2:0]  dx;
    logic [2:0]  dy;
    logic [7:0]  ts;
    logic [31:0] d;
  } req_t;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_seq;
  logic [7:0] tb_age;
  req_t       q[$];
  req_t       e;

  // Reference age counter: counts edges since reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_age <= 8'd0;
    else        tb_age <= tb_age + 8'd1;

  function automatic logic [56:0] mk(input req_t r, input logic [3:0] sq);
    return {1'b1, 3'd1, 3'd2, r.dx, r.dy, r.ts, sq, r.d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] dx, input logic [2:0] dy,
                      input logic [31:0] d, input bit accepted);
    bus.req_valid = 1'b1;
    bus.req_dstX  = dx;
    bus.req_dstY  = dy;
    bus.req_data  = d;
    if (accepted) q.push_back({dx, dy, tb_age, d});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_dstX = '0; bus.req_dstY = '0;
    bus.req_data = '0; bus.inj_slot_free = 1'b0;
    exp_seq = 4'd0;
    repeat (2) tick();
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
    total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL rst_fvalid: got %b want 0", bus.flit_valid); end
    total++; if (bus.flit_out !== 57'd0) begin bad++; $display("FAIL rst_flit: got %h want 0", bus.flit_out); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", bus.fifo_count); end
    total++; if (bus.req_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.req_err); end
    rst_n = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_single();
    bus.inj_slot_free = 1'b1;
    send(3'd3, 3'd5, 32'hA5A5A5A5, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL single_lat: got %b want 0", bus.flit_valid); end
    total++; if (bus.fifo_count !== 3'd1) begin bad++; $display("FAIL single_cnt1: got %0d want 1", bus.fifo_count); end
    tick();
    e = q.pop_front();
    total++; if (bus.flit_valid !== 1'b1) begin bad++; $display("FAIL single_fvalid: got %b want 1", bus.flit_valid); end
    total++; if (bus.flit_out !== mk(e, exp_seq)) begin bad++; $display("FAIL single_flit: got %h want %h", bus.flit_out, mk(e, exp_seq)); end
    exp_seq++;
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL single_cnt0: got %0d want 0", bus.fifo_count); end
    tick();
    total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL single_pulse: got %b want 0", bus.flit_valid); end
    total++; if (bus.flit_out !== 57'd0) begin bad++; $display("FAIL single_clear: got %h want 0", bus.flit_out); end
  endtask

  task automatic test_fill();
    bus.inj_slot_free = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(3'(i), 3'(i + 1), 32'h1000 + 32'(i), i < 4);
      tick();
      total++; if (bus.fifo_count !== 3'(i < 4 ? i + 1 : 4)) begin bad++; $display("FAIL fill_cnt%0d: got %0d want %0d", i, bus.fifo_count, (i < 4 ? i + 1 : 4)); end
    end
    bus.req_valid = 1'b0;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL fill_ready: got %b want 0", bus.req_ready); end
    total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL fill_noflit: got %b want 0", bus.flit_valid); end
    bus.inj_slot_free = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = q.pop_front();
      total++; if (bus.flit_out !== mk(e, exp_seq)) begin bad++; $display("FAIL fill_flit%0d: got %h want %h", k, bus.flit_out, mk(e, exp_seq)); end
      exp_seq++;
      total++; if (bus.fifo_count !== 3'(3 - k)) begin bad++; $display("FAIL fill_drain%0d: got %0d want %0d", k, bus.fifo_count, 3 - k); end
    end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_back: got %b want 1", bus.req_ready); end
    tick();
    total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL fill_empty: got %b want 0", bus.flit_valid); end
  endtask

  task automatic test_bad_coord();
    bus.inj_slot_free = 1'b1;
    send(3'd6, 3'd1, 32'h0000BAD0, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    total++; if (bus.req_err !== 1'b1) begin bad++; $display("FAIL badx_err: got %b want 1", bus.req_err); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL badx_cnt: got %0d want 0", bus.fifo_count); end
    tick();
    total++; if (bus.req_err !== 1'b0) begin bad++; $display("FAIL badx_pulse: got %b want 0", bus.req_err); end
    total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL badx_noflit: got %b want 0", bus.flit_valid); end
    send(3'd1, 3'd7, 32'h0000BAD1, 1'b0);
    tick();
    total++; if (bus.req_err !== 1'b1) begin bad++; $display("FAIL bady_err: got %b want 1", bus.req_err); end
    send(3'd5, 3'd5, 32'h00000055, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    total++; if (bus.req_err !== 1'b0) begin bad++; $display("FAIL edge_err: got %b want 0", bus.req_err); end
    total++; if (bus.fifo_count !== 3'd1) begin bad++; $display("FAIL edge_cnt: got %0d want 1", bus.fifo_count); end
    tick();
    e = q.pop_front();
    total++; if (bus.flit_out !== mk(e, exp_seq)) begin bad++; $display("FAIL edge_flit: got %h want %h", bus.flit_out, mk(e, exp_seq)); end
    exp_seq++;
    tick();
  endtask

  task automatic test_full_pop();
    bus.inj_slot_free = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(3'(i), 3'(5 - i), 32'hC0 + 32'(i), 1'b1);
      tick();
    end
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL full_cnt: got %0d want 4", bus.fifo_count); end
    send(3'd4, 3'd4, 32'hC4, 1'b0);
    bus.inj_slot_free = 1'b1;
    tick();
    total++; if (bus.fifo_count !== 3'd3) begin bad++; $display("FAIL fullpop_cnt: got %0d want 3", bus.fifo_count); end
    e = q.pop_front();
    total++; if (bus.flit_out !== mk(e, exp_seq)) begin bad++; $display("FAIL fullpop_flit: got %h want %h", bus.flit_out, mk(e, exp_seq)); end
    exp_seq++;
    send(3'd4, 3'd4, 32'hC4, 1'b1);
    bus.inj_slot_free = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    total++; if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL refill_cnt: got %0d want 4", bus.fifo_count); end
    bus.inj_slot_free = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = q.pop_front();
      total++; if (bus.flit_out !== mk(e, exp_seq)) begin bad++; $display("FAIL full_drain%0d: got %h want %h", k, bus.flit_out, mk(e, exp_seq)); end
      exp_seq++;
    end
    bus.inj_slot_free = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.inj_slot_free = 1'b0;
    bus.req_valid = 1'b0;
    for (int n = 0; n < 300 && tb_age != 8'd248; n++) tick();
    bus.inj_slot_free = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) begin
        bus.req_valid = 1'b1;
        bus.req_dstX  = 3'(i % 6);
        bus.req_dstY  = 3'((i + 3) % 6);
        bus.req_data  = 32'hF0000000 + 32'(i);
        q.push_back({3'(i % 6), 3'((i + 3) % 6), 8'(248 + i), 32'hF0000000 + 32'(i)});
      end else begin
        bus.req_valid = 1'b0;
      end
      tick();
      if (i > 0) begin
        e = q.pop_front();
        total++; if (bus.flit_out !== mk(e, exp_seq)) begin bad++; $display("FAIL b2b_flit%0d: got %h want %h", i - 1, bus.flit_out, mk(e, exp_seq)); end
        exp_seq++;
      end
      total++; if (bus.fifo_count !== 3'(i < 17 ? 1 : 0)) begin bad++; $display("FAIL b2b_cnt%0d: got %0d want %0d", i, bus.fifo_count, (i < 17 ? 1 : 0)); end
    end
    tick();
    total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", bus.flit_valid); end
  endtask

  task automatic test_reset_mid();
    bus.inj_slot_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(3'(i + 1), 3'd2, 32'h77 + 32'(i), 1'b1);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.inj_slot_free = 1'b1;
    tick();
    total++; if (bus.flit_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", bus.flit_valid); end
    total++; if (bus.fifo_count !== 3'd2) begin bad++; $display("FAIL mid_pre_cnt: got %0d want 2", bus.fifo_count); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", bus.flit_valid); end
    total++; if (bus.flit_out !== 57'd0) begin bad++; $display("FAIL mid_async_flit: got %h want 0", bus.flit_out); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL mid_async_cnt: got %0d want 0", bus.fifo_count); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL mid_async_ready: got %b want 0", bus.req_ready); end
    q.delete();
    exp_seq = 4'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    send(3'd4, 3'd0, 32'hDEADBEEF, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    e = q.pop_front();
    total++; if (bus.flit_out !== mk(e, exp_seq)) begin bad++; $display("FAIL mid_first_flit: got %h want %h", bus.flit_out, mk(e, exp_seq)); end
    tick();
    total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL mid_idle: got %b want 0", bus.flit_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_bad_coord();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end
endmodule
